boot_loader_dma: RTL and testbench

Synthesizable program loader. It takes a byte stream from a host link (UART or debug bridge), packs the bytes into memory words, and writes them to program memory starting at an entry address. An optional read-back checksum pass verifies the image. It holds the CPU in reset until the load succeeds, then releases it after a programmable hold time. It sits between the host byte source, the memory write/read port, and cpu_resetn of the RISC-V core.

---
 rtl/boot_loader_dma.sv | 164 ++++++++++++++++
 tb/tb_boot_loader_dma.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_dma.sv
// boot_loader_dma: packs a host byte stream into memory words, optionally verifies them by read-back checksum, then releases the CPU reset.
module boot_loader_dma #(
    parameter int                  P_DATA_WIDTH  = 32,
    parameter int                  P_ADDR_WIDTH  = 32,
    parameter logic [P_ADDR_WIDTH-1:0] P_ADDR_ENTRY = '0,
    parameter logic [P_ADDR_WIDTH:0]   P_ADDR_LIMIT = 'h1_0000,
    parameter int                  P_SWAP        = 0,
    parameter int                  P_VERIFY      = 1,
    parameter int                  P_HOLD_CYCLES = 5,
    parameter logic [31:0]         P_BOOT_VECTOR = 32'h0
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      start,
    input  logic [31:0]               len_bytes,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [7:0]                s_data,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    output logic [P_ADDR_WIDTH-1:0]   m_waddr,
    output logic [P_DATA_WIDTH-1:0]   m_wdata,
    output logic [P_DATA_WIDTH/8-1:0] m_wstrb,
    output logic                      m_rvalid_req,
    input  logic                      m_rready_req,
    output logic [P_ADDR_WIDTH-1:0]   m_raddr,
    input  logic                      m_rvalid,
    input  logic [P_DATA_WIDTH-1:0]   m_rdata,
    output logic                      cpu_resetn,
    output logic [31:0]               boot_vector,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [1:0]                err_code,
    output logic [31:0]               words_written
);
    localparam int W  = P_DATA_WIDTH / 8;
    localparam int KW = $clog2(W) + 1;

    typedef enum logic [2:0] {IDLE, FILL, WRITE, VERIFY_REQ, VERIFY_WAIT, HOLD, RUN, ERROR} state_t;

    state_t                  state, state_n;
    logic [31:0]             remain, hold_cnt, vcnt;
    logic [P_ADDR_WIDTH-1:0] addr, raddr;
    logic [P_ADDR_WIDTH:0]   addr_end;
    logic [P_DATA_WIDTH-1:0] wdata, csum, rsum, rsum_n, rmask;
    logic [W-1:0]            wstrb, last_strb;
    logic [KW-1:0]           k, lane;
    logic                    ovf, in_fire, w_fire, r_last, hold_done;

    assign addr_end  = {1'b0, addr} + (P_ADDR_WIDTH+1)'(W);
    assign ovf       = addr_end > P_ADDR_LIMIT;
    assign in_fire   = s_valid && s_ready;
    assign w_fire    = m_wvalid && m_wready;
    assign r_last    = vcnt + 32'd1 >= words_written;
    assign hold_done = hold_cnt + 32'd1 >= 32'(P_HOLD_CYCLES);
    assign lane      = (P_SWAP != 0) ? KW'(W - 1) - k : k;
    assign rsum_n    = rsum + (m_rdata & rmask);

    assign m_waddr     = addr;
    assign m_wdata     = wdata;
    assign m_wstrb     = wstrb;
    assign m_raddr     = raddr;
    assign cpu_resetn  = state == RUN;
    assign done        = state == RUN;
    assign error       = state == ERROR;
    assign busy        = !(state == IDLE || state == RUN || state == ERROR);
    assign boot_vector = P_BOOT_VECTOR;

    // Only the final word may be partial; earlier words compare every lane.
    always_comb begin
        rmask = '0;
        for (int i = 0; i < W; i++) rmask[8*i +: 8] = {8{!r_last || last_strb[i]}};
    end

    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n      = state;
        s_ready      = 1'b0;
        m_wvalid     = 1'b0;
        m_rvalid_req = 1'b0;
        case (state)
            IDLE:        if (start) state_n = (len_bytes == 32'd0) ? HOLD : FILL;
            FILL: begin
                s_ready = 1'b1;
                if (s_valid && (k == KW'(W - 1) || remain == 32'd1)) state_n = WRITE;
            end
            WRITE: begin
                m_wvalid = !ovf;
                if (ovf) state_n = ERROR;
                else if (m_wready) state_n = (remain != 32'd0) ? FILL : (P_VERIFY != 0) ? VERIFY_REQ : HOLD;
            end
            VERIFY_REQ: begin
                m_rvalid_req = 1'b1;
                if (m_rready_req) state_n = VERIFY_WAIT;
            end
            VERIFY_WAIT: if (m_rvalid) state_n = !r_last ? VERIFY_REQ : (rsum_n == csum) ? HOLD : ERROR;
            HOLD:        if (hold_done) state_n = RUN;
            default:     state_n = state;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            remain        <= '0;
            addr          <= '0;
            raddr         <= '0;
            wdata         <= '0;
            wstrb         <= '0;
            last_strb     <= '0;
            k             <= '0;
            csum          <= '0;
            rsum          <= '0;
            vcnt          <= '0;
            hold_cnt      <= '0;
            err_code      <= '0;
            words_written <= '0;
        end else begin
            if (state == IDLE && start) begin
                remain        <= len_bytes;
                addr          <= P_ADDR_ENTRY;
                csum          <= '0;
                k             <= '0;
                wdata         <= '0;
                wstrb         <= '0;
                words_written <= '0;
                hold_cnt      <= '0;
                err_code      <= '0;
            end
            if (in_fire) begin
                wdata[lane*8 +: 8] <= s_data;
                wstrb[lane]        <= 1'b1;
                k                  <= k + KW'(1);
                remain             <= remain - 32'd1;
            end
            if (state == WRITE && ovf) err_code <= 2'd1;
            // Readback bookkeeping is re-armed on every beat so it is fresh when verify begins.
            if (w_fire) begin
                csum          <= csum + wdata;
                words_written <= words_written + 32'd1;
                addr          <= addr + P_ADDR_WIDTH'(W);
                k             <= '0;
                wdata         <= '0;
                wstrb         <= '0;
                last_strb     <= wstrb;
                raddr         <= P_ADDR_ENTRY;
                rsum          <= '0;
                vcnt          <= '0;
                hold_cnt      <= '0;
            end
            if (state == VERIFY_WAIT && m_rvalid) begin
                rsum  <= rsum_n;
                raddr <= raddr + P_ADDR_WIDTH'(W);
                vcnt  <= vcnt + 32'd1;
                if (r_last && rsum_n != csum) err_code <= 2'd2;
            end
            if (state == HOLD) hold_cnt <= hold_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_boot_loader_dma.sv
// tb_boot_loader_dma: directed loads against three parameterisations, checked every cycle against a word-level image model.
module tb_boot_loader_dma;
    logic aclk = 1'b0, areset = 1'b1, start = 1'b0;
    logic [31:0] len_bytes = '0;
    logic s_valid = 1'b0, m_wready = 1'b0, m_rready_req = 1'b0, m_rvalid = 1'b0;
    logic [7:0] s_data = '0;
    logic [31:0] m_rdata = '0;
    int sel = 0;

    logic [2:0] start_a;
    logic s_ready_a [3], m_wvalid_a [3], m_rvalid_req_a [3], cpu_resetn_a [3], busy_a [3], done_a [3], error_a [3];
    logic [31:0] m_waddr_a [3], m_wdata_a [3], m_raddr_a [3], boot_vector_a [3], words_written_a [3];
    logic [3:0] m_wstrb_a [3];
    logic [1:0] err_code_a [3];

    logic s_ready, m_wvalid, m_rvalid_req, cpu_resetn, busy, done, error;
    logic [31:0] m_waddr, m_wdata, m_raddr, boot_vector, words_written;
    logic [3:0] m_wstrb;
    logic [1:0] err_code;

    always #5 aclk = ~aclk;

    // Instance 0: defaults, 1: MSB-first lanes, 2: loadable memory ends at 0x8.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign start_a[g] = start && sel == g;
        boot_loader_dma #(.P_SWAP(g == 1 ? 1 : 0), .P_ADDR_LIMIT(g == 2 ? 33'h8 : 33'h1_0000)) u_dut (
            .aclk(aclk), .areset(areset), .start(start_a[g]), .len_bytes(len_bytes),
            .s_valid(s_valid), .s_ready(s_ready_a[g]), .s_data(s_data),
            .m_wvalid(m_wvalid_a[g]), .m_wready(m_wready), .m_waddr(m_waddr_a[g]),
            .m_wdata(m_wdata_a[g]), .m_wstrb(m_wstrb_a[g]),
            .m_rvalid_req(m_rvalid_req_a[g]), .m_rready_req(m_rready_req), .m_raddr(m_raddr_a[g]),
            .m_rvalid(m_rvalid), .m_rdata(m_rdata),
            .cpu_resetn(cpu_resetn_a[g]), .boot_vector(boot_vector_a[g]), .busy(busy_a[g]),
            .done(done_a[g]), .error(error_a[g]), .err_code(err_code_a[g]), .words_written(words_written_a[g])
        );
    end

    always_comb begin
        s_ready       = s_ready_a[sel];
        m_wvalid      = m_wvalid_a[sel];
        m_rvalid_req  = m_rvalid_req_a[sel];
        cpu_resetn    = cpu_resetn_a[sel];
        busy          = busy_a[sel];
        done          = done_a[sel];
        error         = error_a[sel];
        m_waddr       = m_waddr_a[sel];
        m_wdata       = m_wdata_a[sel];
        m_wstrb       = m_wstrb_a[sel];
        m_raddr       = m_raddr_a[sel];
        boot_vector   = boot_vector_a[sel];
        words_written = words_written_a[sel];
        err_code      = err_code_a[sel];
    end

    int checks = 0, failures = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Image model: expected write beats and final outcome derived from the byte list.
    typedef struct packed { logic [31:0] a; logic [31:0] d; logic [3:0] s; } wr_t;
    wr_t exp_w[$];
    logic [7:0] img[$], src[$];
    logic [31:0] mem [64];
    int swap_m, limit_m, corrupt, exp_err, stall;

    task automatic build_model();
        wr_t e;
        exp_w.delete();
        exp_err = 0;
        for (int w = 0; 4 * w < img.size(); w++) begin
            if (4 * w + 4 > limit_m) begin exp_err = 1; break; end
            e = '0;
            e.a = 32'(4 * w);
            for (int j = 0; j < 4; j++)
                if (4 * w + j < img.size()) begin
                    e.d[8 * (swap_m != 0 ? 3 - j : j) +: 8] = img[4 * w + j];
                    e.s[swap_m != 0 ? 3 - j : j] = 1'b1;
                end
            exp_w.push_back(e);
        end
        if (exp_err == 0 && corrupt >= 0 && corrupt / 4 < exp_w.size()) exp_err = 2;
    endtask

    // Host, memory and compare process; decisions are made on the falling edge for the next rising edge.
    int cyc = 0, ev_cyc = -100, wr_idx = 0, rd_idx = 0, rd_pend = -1;
    bit s_fire_prev = 0, w_hold = 0, rise_seen = 0;
    logic [31:0] pa, pd, raddr_lat;
    logic [3:0] ps;
    always @(negedge aclk) begin
        cyc++;
        if (areset) begin
            s_valid = 0; m_wready = 0; m_rready_req = 0; m_rvalid = 0;
            s_fire_prev = 0; w_hold = 0; rd_pend = -1;
        end else begin
            if (s_fire_prev) void'(src.pop_front());
            s_valid = src.size() > 0;
            s_data = s_valid ? src[0] : 8'h00;
            s_fire_prev = s_valid && s_ready;
            if (w_hold) chk("wr_stable", {m_wvalid, m_waddr, m_wstrb}, {1'b1, pa, ps});
            if (w_hold) chk("wr_stable_data", m_wdata, pd);
            m_wready = !(m_wvalid && stall > 0);
            if (m_wvalid && stall > 0) stall--;
            if (m_wvalid) begin
                chk("sready_in_write", s_ready, 0);
                if (wr_idx < exp_w.size()) chk("write_beat", {m_waddr, m_wdata, m_wstrb}, exp_w[wr_idx]);
                else chk("extra_write", m_waddr, 32'hFFFF_FFFF);
                if (m_wready) begin
                    for (int j = 0; j < 4; j++) if (m_wstrb[j]) mem[m_waddr[7:2]][8*j +: 8] = m_wdata[8*j +: 8];
                    wr_idx++;
                end
            end
            w_hold = m_wvalid && !m_wready;
            pa = m_waddr; pd = m_wdata; ps = m_wstrb;
            m_rvalid = 0;
            if (rd_pend == 0) begin
                m_rvalid = 1;
                m_rdata = mem[raddr_lat[7:2]] ^ (int'(raddr_lat) == corrupt ? 32'h100 : 32'h0);
                rd_pend = -1;
                rd_idx++;
                if (rd_idx == exp_w.size()) ev_cyc = cyc;
            end else if (rd_pend > 0) rd_pend--;
            m_rready_req = ~m_rready_req;
            if (m_rvalid_req) chk("one_outstanding", {m_rvalid, rd_pend >= 0}, 0);
            if (m_rvalid_req && m_rready_req) begin
                chk("raddr", m_raddr, 32'(4 * rd_idx));
                raddr_lat = m_raddr;
                rd_pend = 1;
            end
            if (start && len_bytes == 0) ev_cyc = cyc;
            if (cpu_resetn && !rise_seen) begin
                rise_seen = 1;
                chk("hold_time", cyc, ev_cyc + 6);
            end
            chk("flags", {done, boot_vector, error && busy}, {cpu_resetn, 32'h0, 1'b0});
        end
    end

    task automatic do_reset();
        @(posedge aclk); #1 areset = 1; start = 0;
        repeat (2) @(posedge aclk);
        #1 areset = 0;
    endtask

    task automatic pulse_start(input logic [31:0] n);
        @(posedge aclk); #1 start = 1; len_bytes = n;
        @(posedge aclk); #1 start = 0;
    endtask

    task automatic run(input int s, input int n, input logic [7:0] b0, input int st, input int cor);
        @(posedge aclk); #1 areset = 1;
        sel = s; swap_m = (s == 1); limit_m = (s == 2) ? 8 : 'h10000;
        corrupt = cor; stall = st;
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(b0 + 8'(i));
        src = img;
        build_model();
        for (int i = 0; i < 64; i++) mem[i] = '0;
        wr_idx = 0; rd_idx = 0; rise_seen = 0; ev_cyc = -100;
        do_reset();
        pulse_start(32'(n));
        for (int i = 0; i < 3000 && !(done || error); i++) @(negedge aclk);
        chk("load_timeout", done || error, 1);
        repeat (3) @(negedge aclk);
        chk("outcome", {done, error, err_code, cpu_resetn}, {exp_err == 0, exp_err != 0, 2'(exp_err), exp_err == 0});
        chk("words_written", words_written, 32'(exp_w.size()));
        chk("writes_seen", wr_idx, exp_w.size());
        chk("reads_seen", rd_idx, exp_err == 1 ? 0 : exp_w.size());
        chk("released", rise_seen, exp_err == 0);
    endtask

    initial begin
        do_reset();
        @(negedge aclk);
        chk("reset_vals", {cpu_resetn, s_ready, m_wvalid, m_rvalid_req, busy, done, error, err_code, words_written}, 0);

        run(0, 8, 8'h01, 0, -1);
        chk("t1_word0", mem[0], 32'h0403_0201);
        chk("t1_word1", mem[1], 32'h0807_0605);

        run(1, 6, 8'h11, 0, -1);
        chk("t2_word0", mem[0], 32'h1112_1314);
        chk("t2_word1", mem[1], 32'h1516_0000);
        chk("t2_model_strb", exp_w[1].s, 4'hC);

        run(0, 8, 8'h21, 10, -1);
        chk("t3_stall_used", stall, 0);
        chk("t3_word1", mem[1], 32'h2827_2625);

        run(0, 8, 8'h01, 0, 4);
        chk("t4_err_code", err_code, 2'd2);

        run(2, 12, 8'h31, 0, -1);
        chk("t5_err_code", err_code, 2'd1);
        chk("t5_no_write_8", mem[2], 32'h0);

        @(posedge aclk); #1 areset = 1;
        sel = 0; stall = 0; corrupt = -1; swap_m = 0; limit_m = 'h10000;
        img.delete();
        for (int i = 0; i < 8; i++) img.push_back(8'h41 + 8'(i));
        src = img;
        build_model();
        wr_idx = 0; rd_idx = 0;
        do_reset();
        pulse_start(32'd8);
        @(negedge aclk);
        chk("t6_mid_fill", {busy, s_ready}, 2'b11);
        @(posedge aclk); #1 areset = 1; src.delete();
        @(posedge aclk);
        @(negedge aclk);
        chk("t6_abort", {cpu_resetn, s_ready, m_wvalid, m_rvalid_req, busy, done, error, err_code, words_written}, 0);
        #1 areset = 0;
        @(negedge aclk);
        chk("t6_idle", {cpu_resetn, s_ready, m_wvalid, m_rvalid_req, busy, done, error, err_code, words_written}, 0);

        run(0, 0, 8'h00, 0, -1);
        pulse_start(32'd8);
        repeat (5) @(negedge aclk);
        chk("t6_run_ignores_start", {done, cpu_resetn, busy, s_ready, words_written}, {1'b1, 1'b1, 1'b0, 1'b0, 32'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
